// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM generator. Counts are loaded into a shadow set, and each channel
// adopts the shadow set only at its own period boundary.
module rgb_pwm_ch #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          pending,
  input  logic [DW-1:0] sh_high,
  input  logic [DW-1:0] sh_low,
  output logic          pwm,
  output logic          pstart,
  output logic          adopt
);
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  state_t        state, state_d;
  logic [DW-1:0] cnt, cnt_d;
  logic [DW-1:0] act_high, act_low, act_high_d, act_low_d;
  logic [DW-1:0] new_high, new_low;
  logic          last_high, last_low, start;

  // HIGH/LOW are entered only with a nonzero active count, so the -1 never wraps in use
  assign last_high = (cnt == act_high - DW'(1));
  assign last_low  = (cnt == act_low  - DW'(1));
  assign new_high  = pending ? sh_high : act_high;
  assign new_low   = pending ? sh_low  : act_low;

  always_comb begin
    start = 1'b0;
    if (enable) begin
      case (state)
        IDLE:    start = 1'b1;
        HIGH:    start = last_high && (act_low == '0);
        LOW:     start = last_low;
        default: start = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      act_high <= '0;
      act_low  <= '0;
      pwm      <= 1'b0;
      pstart   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      act_high <= act_high_d;
      act_low  <= act_low_d;
      pwm      <= (state_d == HIGH);
      pstart   <= start;
    end
  end

  always_comb begin
    state_d = state;
    if (!enable)
      state_d = IDLE;
    else if (start)
      state_d = (new_high != '0) ? HIGH : ((new_low != '0) ? LOW : IDLE);
    else if (state == HIGH && last_high)
      state_d = LOW;
  end

  always_comb begin
    adopt      = start && pending;
    act_high_d = start ? new_high : act_high;
    act_low_d  = start ? new_low  : act_low;
    if (!enable || start || (state == HIGH && last_high))
      cnt_d = '0;
    else
      cnt_d = cnt + DW'(1);
  end
endmodule

module rgb_pwm_gen #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          load,
  input  logic [DW-1:0] red_high_count,
  input  logic [DW-1:0] red_low_count,
  input  logic [DW-1:0] green_high_count,
  input  logic [DW-1:0] green_low_count,
  input  logic [DW-1:0] blue_high_count,
  input  logic [DW-1:0] blue_low_count,
  output logic          red,
  output logic          green,
  output logic          blue,
  output logic [2:0]    period_start,
  output logic          upd_pending
);
  localparam int NUM_CH = 3;

  logic [NUM_CH-1:0][DW-1:0] in_high, in_low, sh_high, sh_low;
  logic [NUM_CH-1:0]         pending, adopt, pwm;

  assign in_high = {blue_high_count, green_high_count, red_high_count};
  assign in_low  = {blue_low_count,  green_low_count,  red_low_count};

  // A load coinciding with an adopt wins, so the new values wait for the next boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_high <= '0;
      sh_low  <= '0;
      pending <= '0;
    end else if (load) begin
      sh_high <= in_high;
      sh_low  <= in_low;
      pending <= '1;
    end else begin
      pending <= pending & ~adopt;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rgb_pwm_ch #(.DW(DW)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .pending (pending[i]),
      .sh_high (sh_high[i]),
      .sh_low  (sh_low[i]),
      .pwm     (pwm[i]),
      .pstart  (period_start[i]),
      .adopt   (adopt[i])
    );
  end

  assign red         = pwm[0];
  assign green       = pwm[1];
  assign blue        = pwm[2];
  assign upd_pending = |pending;
endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Directed bench for rgb_pwm_gen: hand-computed waveforms per scenario.
module tb_rgb_pwm_gen;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [DW-1:0] red_high_count = '0, red_low_count = '0;
  logic [DW-1:0] green_high_count = '0, green_low_count = '0;
  logic [DW-1:0] blue_high_count = '0, blue_low_count = '0;
  logic          red, green, blue, upd_pending;
  logic [2:0]    period_start;

  int ntests = 0;
  int nfail  = 0;

  rgb_pwm_gen #(.DW(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .load             (load),
    .red_high_count   (red_high_count),
    .red_low_count    (red_low_count),
    .green_high_count (green_high_count),
    .green_low_count  (green_low_count),
    .blue_high_count  (blue_high_count),
    .blue_low_count   (blue_low_count),
    .red              (red),
    .green            (green),
    .blue             (blue),
    .period_start     (period_start),
    .upd_pending      (upd_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_counts(input int rh, input int rl, input int gh, input int gl,
                            input int bh, input int bl);
    red_high_count   = DW'(rh);
    red_low_count    = DW'(rl);
    green_high_count = DW'(gh);
    green_low_count  = DW'(gl);
    blue_high_count  = DW'(bh);
    blue_low_count   = DW'(bl);
  endtask

  task automatic do_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    logic [9:0]  p1_red, p1_ps;
    logic [14:0] p2_red, p2_upd, p2_ps;
    logic [14:0] p3_g, p3_b;
    logic [8:0]  p6_red, p6_upd;

    // reset state
    #3;
    chk("rst_rgb", {29'd0, blue, green, red}, 32'd0);
    chk("rst_ps", {29'd0, period_start}, 32'd0);
    chk("rst_upd", {31'd0, upd_pending}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // red 3/2: 1,1,1,0,0 repeating, pulse every 5 cycles
    set_counts(3, 2, 0, 0, 0, 0);
    do_load();
    chk("t1_upd_loaded", {31'd0, upd_pending}, 32'd1);
    chk("t1_red_idle", {31'd0, red}, 32'd0);
    enable = 1'b1;
    p1_red = 10'b1110011100;
    p1_ps  = 10'b1000010000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t1_red", {31'd0, red}, {31'd0, p1_red[9-i]});
      chk("t1_ps", {29'd0, period_start}, {29'd0, 2'b11, p1_ps[9-i]});
      chk("t1_upd", {31'd0, upd_pending}, 32'd0);
    end

    // red 4/4 running; load 2/6 during HIGH takes effect at next boundary
    enable = 1'b0;
    step();
    set_counts(4, 4, 0, 0, 0, 0);
    do_load();
    enable = 1'b1;
    step();
    chk("t2_red_e0", {31'd0, red}, 32'd1);
    set_counts(2, 6, 0, 0, 0, 0);
    do_load();
    chk("t2_upd_e1", {31'd0, upd_pending}, 32'd1);
    chk("t2_red_e1", {31'd0, red}, 32'd1);
    p2_red = 15'b110000110000001;
    p2_upd = 15'b111111000000000;
    p2_ps  = 15'b000000100000001;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t2_red", {31'd0, red}, {31'd0, p2_red[14-i]});
      chk("t2_upd", {31'd0, upd_pending}, {31'd0, p2_upd[14-i]});
      chk("t2_ps0", {31'd0, period_start[0]}, {31'd0, p2_ps[14-i]});
    end

    // green 0/5 stays low, blue 7/0 stays high
    enable = 1'b0;
    step();
    set_counts(0, 0, 0, 5, 7, 0);
    do_load();
    enable = 1'b1;
    p3_g = 15'b100001000010000;
    p3_b = 15'b100000010000001;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t3_green", {31'd0, green}, 32'd0);
      chk("t3_blue", {31'd0, blue}, 32'd1);
      chk("t3_ps", {29'd0, period_start}, {29'd0, p3_b[14-i], p3_g[14-i], 1'b1});
    end

    // all counts zero
    enable = 1'b0;
    step();
    set_counts(0, 0, 0, 0, 0, 0);
    do_load();
    chk("t4_upd_before", {31'd0, upd_pending}, 32'd1);
    enable = 1'b1;
    step();
    chk("t4_upd_after", {31'd0, upd_pending}, 32'd0);
    chk("t4_rgb", {29'd0, blue, green, red}, 32'd0);
    step();
    chk("t4_rgb2", {29'd0, blue, green, red}, 32'd0);
    chk("t4_ps", {29'd0, period_start}, 32'd7);

    // red 10/10, drop enable in HIGH, re-enable gives a full HIGH phase
    enable = 1'b0;
    step();
    set_counts(10, 10, 0, 0, 0, 0);
    do_load();
    enable = 1'b1;
    step();
    step();
    step();
    chk("t5_red_high", {31'd0, red}, 32'd1);
    enable = 1'b0;
    step();
    chk("t5_red_off", {31'd0, red}, 32'd0);
    chk("t5_ps_off", {29'd0, period_start}, 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      chk("t5_red_re", {31'd0, red}, (i < 10) ? 32'd1 : 32'd0);
      if (i == 0) chk("t5_ps_re", {31'd0, period_start[0]}, 32'd1);
    end

    // load coincident with red boundary: old shadow used for that period
    enable = 1'b0;
    step();
    set_counts(2, 2, 0, 0, 0, 0);
    do_load();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_red_pre", {31'd0, red}, (i < 2) ? 32'd1 : 32'd0);
    end
    set_counts(3, 1, 0, 0, 0, 0);
    load = 1'b1;
    p6_red = 9'b110011101;
    p6_upd = 9'b111100000;
    for (int i = 0; i < 9; i++) begin
      step();
      load = 1'b0;
      chk("t6_red", {31'd0, red}, {31'd0, p6_red[8-i]});
      chk("t6_upd", {31'd0, upd_pending}, {31'd0, p6_upd[8-i]});
      if (i == 0) chk("t6_ps_boundary", {31'd0, period_start[0]}, 32'd1);
    end

    // async reset mid-LOW, between clock edges
    set_counts(3, 1, 0, 0, 7, 0);
    do_load();
    step();
    step();
    chk("t7_red_low", {31'd0, red}, 32'd0);
    chk("t7_blue", {31'd0, blue}, 32'd1);
    chk("t7_upd", {31'd0, upd_pending}, 32'd1);
    chk("t7_ps", {29'd0, period_start}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_rgb", {29'd0, blue, green, red}, 32'd0);
    chk("t7_rst_ps", {29'd0, period_start}, 32'd0);
    chk("t7_rst_upd", {31'd0, upd_pending}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
